// File: rtl/sda_pkg.sv
// Shared definitions for the SDA burst writer: parameter defaults, the
// controller state encoding and a small width helper.
package sda_pkg;

    localparam int SDA_ADDR_W    = 8;
    localparam int SDA_DATA_W    = 8;
    localparam int SDA_MAX_BURST = 16;
    localparam int SDA_ACK_CHECK = 1;

    // Controller states, in the order a normal transfer visits them.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_DATA      = 3'd4,
        ST_DATA_ACK  = 3'd5,
        ST_STOP      = 3'd6
    } state_e;

    // Larger of two widths; sizes the shared address/data shift register.
    function automatic int sda_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sda_shifter.sv
// Loadable MSB-first shift register with a bits-remaining counter.
// The caller left-aligns the word in data_i and says how many bits are
// meaningful in nbits_i; last_o is high while the final bit is on bit_o.
module sda_shifter #(
    parameter int  W     = 8,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [W-1:0]     data_i,
    input  logic [CNT_W-1:0] nbits_i,
    output logic             bit_o,
    output logic             last_o
);

    logic [W-1:0]     sreg_q;
    logic [CNT_W-1:0] cnt_q;

    // Load takes priority over shift; the counter stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
            cnt_q  <= nbits_i;
        end else if (shift_i) begin
            sreg_q <= sreg_q << 1;
            cnt_q  <= (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        end
    end

    assign bit_o  = sreg_q[W-1];
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sda_burst_writer.sv
// Serial burst writer: sends an address, then up to MAX_BURST data words,
// MSB first on a single open line, with an optional ack slot after every
// word. Any nack ends the transfer early.
//
// wdata handshake: wdata_ready is high only in WAIT_DATA; a word is taken
// on a rising edge where wdata_ready and wdata_valid are both high. The
// source may raise wdata_valid before wdata_ready and must hold wdata
// stable while wdata_valid is high and the word has not been taken.
//
// dbg = {sda output enable, state} for observing the controller.
module sda_burst_writer
    import sda_pkg::*;
#(
    parameter int  ADDR_W    = SDA_ADDR_W,
    parameter int  DATA_W    = SDA_DATA_W,
    parameter int  MAX_BURST = SDA_MAX_BURST,
    parameter int  ACK_CHECK = SDA_ACK_CHECK,
    localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    inout  wire               sda,
    output logic              busy,
    output logic              done,
    output logic              nack,
    output logic [LEN_W-1:0]  words_sent,
    output logic [3:0]        dbg
);

    localparam int SH_W     = sda_max(ADDR_W, DATA_W);
    localparam int SH_CNT_W = $clog2(SH_W + 1);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   words_sent_q;
    logic               sda_oe_q;
    logic               busy_q;
    logic               done_q;
    logic               nack_q;
    logic               wdata_ready_q;

    logic               sh_load;
    logic               sh_shift;
    logic [SH_W-1:0]    sh_din;
    logic [SH_CNT_W-1:0] sh_nbits;
    logic               sh_bit;
    logic               sh_last;

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   words_sent_inc;
    logic               last_word;
    logic               ack_seen;

    // Lengths beyond the burst limit are cut down to the limit.
    assign len_clamped    = (len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : len;
    assign words_sent_inc = words_sent_q + LEN_W'(1);
    assign last_word      = (words_sent_inc == len_q);

    // Only a driven low counts as ack; high or an undriven line is a nack.
    assign ack_seen = (sda == 1'b0);

    // Line driver: both the enable and the bit come straight from flops.
    assign sda = sda_oe_q ? sh_bit : 1'bz;

    sda_shifter #(
        .W(SH_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (sh_din),
        .nbits_i (sh_nbits),
        .bit_o   (sh_bit),
        .last_o  (sh_last)
    );

    // Shifter control: load the address on acceptance, a data word on the
    // handshake, and advance one bit per cycle while a word is on the line.
    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = '0;
        sh_nbits = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_load  = 1'b1;
                    sh_din   = SH_W'(addr) << (SH_W - ADDR_W);
                    sh_nbits = SH_CNT_W'(ADDR_W);
                end
            end
            ST_WAIT_DATA: begin
                if (wdata_valid) begin
                    sh_load  = 1'b1;
                    sh_din   = SH_W'(wdata) << (SH_W - DATA_W);
                    sh_nbits = SH_CNT_W'(DATA_W);
                end
            end
            ST_ADDR, ST_DATA: begin
                sh_shift = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Transfer controller; every output it produces is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            words_sent_q  <= '0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            nack_q        <= 1'b0;
            wdata_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            nack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_ADDR;
                        len_q        <= len_clamped;
                        words_sent_q <= '0;
                        busy_q       <= 1'b1;
                        sda_oe_q     <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (sh_last) begin
                        sda_oe_q <= 1'b0;
                        if (ACK_CHECK != 0) begin
                            state_q <= ST_ADDR_ACK;
                        end else if (len_q == '0) begin
                            state_q <= ST_STOP;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= ST_WAIT_DATA;
                            wdata_ready_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (!ack_seen) begin
                        state_q <= ST_STOP;
                        done_q  <= 1'b1;
                        nack_q  <= 1'b1;
                    end else if (len_q == '0) begin
                        state_q <= ST_STOP;
                        done_q  <= 1'b1;
                    end else begin
                        state_q       <= ST_WAIT_DATA;
                        wdata_ready_q <= 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (wdata_valid) begin
                        state_q       <= ST_DATA;
                        wdata_ready_q <= 1'b0;
                        sda_oe_q      <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sh_last) begin
                        sda_oe_q <= 1'b0;
                        if (ACK_CHECK != 0) begin
                            state_q <= ST_DATA_ACK;
                        end else begin
                            // Without ack slots every word sent counts as delivered.
                            words_sent_q <= words_sent_inc;
                            if (last_word) begin
                                state_q <= ST_STOP;
                                done_q  <= 1'b1;
                            end else begin
                                state_q       <= ST_WAIT_DATA;
                                wdata_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DATA_ACK: begin
                    if (!ack_seen) begin
                        // The nacked word is not counted.
                        state_q <= ST_STOP;
                        done_q  <= 1'b1;
                        nack_q  <= 1'b1;
                    end else begin
                        words_sent_q <= words_sent_inc;
                        if (last_word) begin
                            state_q <= ST_STOP;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= ST_WAIT_DATA;
                            wdata_ready_q <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wdata_ready = wdata_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign nack        = nack_q;
    assign words_sent  = words_sent_q;
    assign dbg         = {sda_oe_q, state_q};

endmodule

// File: doc/sda_burst_writer.md
SDA_BURST_WRITER -- requirements
Module: sda_burst_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address bits per transfer.
REQ-002 SHALL have parameter DATA_W, default 8, bits per data word.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum data words per transfer; LEN_W = clog2(MAX_BURST+1).
REQ-004 SHALL have parameter ACK_CHECK, default 1; 1 = insert ack slot after every address/data word, 0 = no ack slots.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  request a transfer; sampled only in IDLE.
REQ-008 SHALL have port addr  in  ADDR_W  address; captured when start is accepted.
REQ-009 SHALL have port len  in  LEN_W  data-word count; captured with addr; 0 = address-only.
REQ-010 SHALL have port wdata  in  DATA_W  next data word.
REQ-011 SHALL have port wdata_valid  in  1  wdata is valid.
REQ-012 SHALL have port wdata_ready  out  1  block will take wdata on this edge if valid.
REQ-013 SHALL have port sda  inout  1  serial line; driven or high-Z.
REQ-014 SHALL have port busy  out  1  transfer in progress.
REQ-015 SHALL have port done  out  1  one-cycle end-of-transfer pulse.
REQ-016 SHALL have port nack  out  1  one-cycle pulse with done when the transfer was aborted by nack.
REQ-017 SHALL have port words_sent  out  LEN_W  data words acknowledged in the last transfer; held until next start.

Function
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, WAIT_DATA, DATA, DATA_ACK, STOP.
REQ-019 SHALL accept start only in IDLE; start asserted in any other state is ignored.
REQ-020 SHALL serialize one bit per clk, MSB first; sda output enable and bit value registered (no combinational path to sda).
REQ-021 SHALL, on acceptance, enter ADDR next cycle and drive addr[ADDR_W-1..0] over ADDR_W consecutive cycles.
REQ-022 SHALL, in ADDR_ACK/DATA_ACK (one cycle each, only if ACK_CHECK=1), release sda and sample it at the closing edge: 0 = ack, 1 or Z = nack.
REQ-023 SHALL, after the address ack with len>0, enter WAIT_DATA with sda released and wdata_ready=1; word loads on the edge where wdata_valid=1, next state DATA.
REQ-024 SHALL hold WAIT_DATA indefinitely while wdata_valid=0; wdata_ready=0 in all other states.
REQ-025 SHALL drive the loaded word over DATA_W cycles, then DATA_ACK; on ack increment words_sent; return to WAIT_DATA if words remain, else STOP.
REQ-026 SHALL go to STOP immediately on any nack, skipping remaining words; words_sent excludes the nacked word.
REQ-027 SHALL go ADDR_ACK (or ADDR if ACK_CHECK=0) -> STOP when len=0.
REQ-028 SHALL treat len>MAX_BURST as MAX_BURST.
REQ-029 SHALL, in STOP (one cycle), release sda, pulse done=1 and nack if aborted; next state IDLE.
REQ-030 SHALL hold busy=1 from the cycle after acceptance through STOP inclusive.
REQ-031 SHALL, for ACK_CHECK=1, len=1, data already valid, take 20 cycles acceptance-to-STOP inclusive (8+1+1+8+1+1 at defaults).

Reset
REQ-032 SHALL on rst=0 immediately: state IDLE, sda high-Z, busy=0, done=0, nack=0, wdata_ready=0, words_sent=0, shift register and counters 0.
REQ-033 SHALL abort a transfer in progress on reset with no done pulse; first start after release behaves as from power-up.

Structure
REQ-034 SHALL place the state enumeration and parameter defaults in shared package sda_pkg.
REQ-035 SHALL instantiate one sub-module sda_shifter: loadable MSB-first shift register with bit counter and last-bit flag, width parameterised.

Verification
REQ-036 SHALL test: addr=0xA5, len=1, wdata=0x3C valid held, slave acks -> sda 10100101, Z, Z, 00111100, Z, Z; done at cycle 20; nack=0; words_sent=1.
REQ-037 SHALL test: len=3, wdata_valid for word 2 delayed 5 cycles -> wdata_ready held 5 cycles, sda Z, no bit lost; words_sent=3.
REQ-038 SHALL test: address nacked (sda left high) -> wdata_ready never 1, done and nack same cycle, words_sent=0.
REQ-039 SHALL test: len=0, addr=0x5A -> address + ack slot + STOP, done at cycle 10, nack=0.
REQ-040 SHALL test: rst low in 4th DATA bit -> sda Z and busy 0 same cycle, no done; next start with addr=0x01 completes normally.
REQ-041 SHALL test: start pulsed while busy -> ignored; ACK_CHECK=0 instance with len=1 -> 18 cycles, no Z slots between words.
